// File: rtl/regfile_write_arbiter.sv
// Arbitrates ALU and load writebacks into a single register-file write port.
// Each requester has a one-entry holding buffer; entries commit oldest first.
module regfile_write_arbiter #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 3
) (
   input  logic                  clock,
   input  logic                  resetN,
   input  logic                  aluReq,
   input  logic [ADDR_WIDTH-1:0] aluAddr,
   input  logic [DATA_WIDTH-1:0] aluData,
   output logic                  aluAck,
   input  logic                  memReq,
   input  logic [ADDR_WIDTH-1:0] memAddr,
   input  logic [DATA_WIDTH-1:0] memData,
   output logic                  memAck,
   output logic                  writeOrder,
   output logic [ADDR_WIDTH-1:0] writeAddr,
   output logic [DATA_WIDTH-1:0] writeData,
   input  logic [ADDR_WIDTH-1:0] readAddr1,
   input  logic [ADDR_WIDTH-1:0] readAddr2,
   output logic                  hazard1,
   output logic                  hazard2,
   output logic                  busy
);

   typedef enum logic [2:0] {
      EMPTY     = 3'd0,
      ALU_ONLY  = 3'd1,
      MEM_ONLY  = 3'd2,
      ALU_FIRST = 3'd3,
      MEM_FIRST = 3'd4
   } state_t;

   state_t                state_r;
   state_t                nextState_s;
   logic                  rrPtr_r;
   logic                  rrToggle_s;
   logic [ADDR_WIDTH-1:0] aluAddr_r;
   logic [DATA_WIDTH-1:0] aluData_r;
   logic [ADDR_WIDTH-1:0] memAddr_r;
   logic [DATA_WIDTH-1:0] memData_r;
   logic                  aluValid_s;
   logic                  memValid_s;
   logic                  grantAlu_s;
   logic                  grantMem_s;
   logic                  aluCap_s;
   logic                  memCap_s;
   logic                  aluKeep_s;
   logic                  memKeep_s;

   // Decode buffer occupancy and the grant from the age-ordered state.
   always_comb begin
      aluValid_s = 1'b0;
      memValid_s = 1'b0;
      grantAlu_s = 1'b0;
      grantMem_s = 1'b0;
      case (state_r)
         ALU_ONLY: begin
            aluValid_s = 1'b1;
            grantAlu_s = 1'b1;
         end
         MEM_ONLY: begin
            memValid_s = 1'b1;
            grantMem_s = 1'b1;
         end
         ALU_FIRST: begin
            aluValid_s = 1'b1;
            memValid_s = 1'b1;
            grantAlu_s = 1'b1;
         end
         MEM_FIRST: begin
            aluValid_s = 1'b1;
            memValid_s = 1'b1;
            grantMem_s = 1'b1;
         end
         default: begin
            aluValid_s = 1'b0;
            memValid_s = 1'b0;
         end
      endcase
   end

   // A buffer being drained this cycle can accept a new entry on the same edge.
   assign aluAck    = (!aluValid_s || grantAlu_s) && resetN;
   assign memAck    = (!memValid_s || grantMem_s) && resetN;
   assign aluCap_s  = aluReq && aluAck;
   assign memCap_s  = memReq && memAck;
   assign aluKeep_s = aluValid_s && !grantAlu_s;
   assign memKeep_s = memValid_s && !grantMem_s;

   // Next age order: a surviving entry is always older than a fresh capture.
   always_comb begin
      nextState_s = EMPTY;
      rrToggle_s  = 1'b0;
      if ((aluKeep_s || aluCap_s) && (memKeep_s || memCap_s)) begin
         if (aluKeep_s) begin
            nextState_s = ALU_FIRST;
         end else if (memKeep_s) begin
            nextState_s = MEM_FIRST;
         end else begin
            nextState_s = rrPtr_r ? MEM_FIRST : ALU_FIRST;
            rrToggle_s  = 1'b1;
         end
      end else if (aluKeep_s || aluCap_s) begin
         nextState_s = ALU_ONLY;
      end else if (memKeep_s || memCap_s) begin
         nextState_s = MEM_ONLY;
      end else begin
         nextState_s = EMPTY;
      end
   end

   // State, holding buffers, round-robin pointer and the registered write port.
   always_ff @(posedge clock) begin
      if (!resetN) begin
         state_r    <= EMPTY;
         rrPtr_r    <= 1'b0;
         aluAddr_r  <= {ADDR_WIDTH{1'b0}};
         aluData_r  <= {DATA_WIDTH{1'b0}};
         memAddr_r  <= {ADDR_WIDTH{1'b0}};
         memData_r  <= {DATA_WIDTH{1'b0}};
         writeOrder <= 1'b0;
         writeAddr  <= {ADDR_WIDTH{1'b0}};
         writeData  <= {DATA_WIDTH{1'b0}};
      end else begin
         state_r <= nextState_s;
         if (rrToggle_s) begin
            rrPtr_r <= ~rrPtr_r;
         end
         if (aluCap_s) begin
            aluAddr_r <= aluAddr;
            aluData_r <= aluData;
         end
         if (memCap_s) begin
            memAddr_r <= memAddr;
            memData_r <= memData;
         end
         if (grantAlu_s) begin
            writeOrder <= 1'b1;
            writeAddr  <= aluAddr_r;
            writeData  <= aluData_r;
         end else if (grantMem_s) begin
            writeOrder <= 1'b1;
            writeAddr  <= memAddr_r;
            writeData  <= memData_r;
         end else begin
            writeOrder <= 1'b0;
         end
      end
   end

   assign hazard1 = (aluValid_s && (aluAddr_r == readAddr1)) ||
                    (memValid_s && (memAddr_r == readAddr1)) ||
                    (writeOrder && (writeAddr == readAddr1));
   assign hazard2 = (aluValid_s && (aluAddr_r == readAddr2)) ||
                    (memValid_s && (memAddr_r == readAddr2)) ||
                    (writeOrder && (writeAddr == readAddr2));
   assign busy    = aluValid_s || memValid_s || writeOrder;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench: queue-based age-order model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_regfile_write_arbiter;

   logic        clock;
   logic        resetN;
   logic        aluReq, memReq;
   logic [2:0]  aluAddr, memAddr, readAddr1, readAddr2;
   logic [15:0] aluData, memData;
   logic        aluAck, memAck, writeOrder, hazard1, hazard2, busy;
   logic [2:0]  writeAddr;
   logic [15:0] writeData;

   int tests = 0;
   int fails = 0;

   regfile_write_arbiter #(.DATA_WIDTH(16), .ADDR_WIDTH(3)) dut (
      .clock(clock), .resetN(resetN),
      .aluReq(aluReq), .aluAddr(aluAddr), .aluData(aluData), .aluAck(aluAck),
      .memReq(memReq), .memAddr(memAddr), .memData(memData), .memAck(memAck),
      .writeOrder(writeOrder), .writeAddr(writeAddr), .writeData(writeData),
      .readAddr1(readAddr1), .readAddr2(readAddr2),
      .hazard1(hazard1), .hazard2(hazard2), .busy(busy)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: pending writes as an age-ordered queue.
   typedef struct packed {
      logic        isMem;
      logic [2:0]  addr;
      logic [15:0] data;
   } entry_t;

   entry_t      q[$];
   logic        rr = 1'b0;
   logic        expWo = 1'b0;
   logic [2:0]  expWa = 3'd0;
   logic [15:0] expWd = 16'd0;
   logic        started = 1'b0;

   function automatic logic mAck(input logic isMem);
      logic inQ;
      inQ = 1'b0;
      foreach (q[i]) if (q[i].isMem == isMem) inQ = 1'b1;
      return !inQ || (q.size() > 0 && q[0].isMem == isMem);
   endfunction

   function automatic logic mHaz(input logic [2:0] ra);
      logic h;
      h = expWo && (expWa == ra);
      foreach (q[i]) if (q[i].addr == ra) h = 1'b1;
      return h;
   endfunction

   always @(posedge clock) begin
      logic aC, mC;
      entry_t ea, em;
      if (!resetN) begin
         q.delete();
         rr = 1'b0;
         expWo = 1'b0;
         expWa = 3'd0;
         expWd = 16'd0;
         started = 1'b1;
      end else begin
         aC = aluReq && mAck(1'b0);
         mC = memReq && mAck(1'b1);
         ea = '{isMem: 1'b0, addr: aluAddr, data: aluData};
         em = '{isMem: 1'b1, addr: memAddr, data: memData};
         if (q.size() > 0) begin
            expWo = 1'b1;
            expWa = q[0].addr;
            expWd = q[0].data;
            void'(q.pop_front());
         end else begin
            expWo = 1'b0;
         end
         if (aC && mC) begin
            if (!rr) begin
               q.push_back(ea);
               q.push_back(em);
            end else begin
               q.push_back(em);
               q.push_back(ea);
            end
            rr = ~rr;
         end else if (aC) begin
            q.push_back(ea);
         end else if (mC) begin
            q.push_back(em);
         end
      end
   end

   // Compare every DUT output against the model away from the active edge.
   always @(negedge clock) begin
      if (started) begin
         chk("m_aluAck", aluAck, mAck(1'b0) && resetN);
         chk("m_memAck", memAck, mAck(1'b1) && resetN);
         chk("m_writeOrder", writeOrder, expWo);
         chk("m_writeAddr", writeAddr, expWa);
         chk("m_writeData", writeData, expWd);
         chk("m_hazard1", hazard1, mHaz(readAddr1));
         chk("m_hazard2", hazard2, mHaz(readAddr2));
         chk("m_busy", busy, (q.size() > 0) || expWo);
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic neg();
      @(negedge clock);
   endtask

   task automatic idle(input int n);
      aluReq = 1'b0;
      memReq = 1'b0;
      repeat (n) step();
   endtask

   task automatic doReset();
      aluReq = 1'b0;
      memReq = 1'b0;
      resetN = 1'b0;
      step();
      resetN = 1'b1;
   endtask

   initial begin
      resetN = 1'b0;
      aluReq = 1'b0; memReq = 1'b0;
      aluAddr = 3'd0; memAddr = 3'd0; aluData = 16'd0; memData = 16'd0;
      readAddr1 = 3'd0; readAddr2 = 3'd0;
      repeat (2) step();
      resetN = 1'b1;
      neg();
      chk("reset_writeOrder", writeOrder, 32'd0);
      chk("reset_writeAddr", writeAddr, 32'd0);
      chk("reset_writeData", writeData, 32'd0);
      chk("reset_busy", busy, 32'd0);

      // Single ALU request
      step();
      aluReq = 1'b1; aluAddr = 3'd3; aluData = 16'h1234;
      neg(); chk("single_ack", aluAck, 32'd1);
      step();
      aluReq = 1'b0;
      neg(); chk("single_t0_wo", writeOrder, 32'd0); chk("single_t0_busy", busy, 32'd1);
      step();
      neg();
      chk("single_t1_wo", writeOrder, 32'd1);
      chk("single_t1_wa", writeAddr, 32'd3);
      chk("single_t1_wd", writeData, 32'h1234);
      step();
      neg(); chk("single_t2_wo", writeOrder, 32'd0); chk("single_t2_busy", busy, 32'd0);

      // Tie with rrPtr=0, then a second tie that must go mem first
      doReset();
      aluReq = 1'b1; aluAddr = 3'd1; aluData = 16'hAAAA;
      memReq = 1'b1; memAddr = 3'd2; memData = 16'h5555;
      step();
      aluReq = 1'b0; memReq = 1'b0;
      step();
      neg(); chk("tie_w1_wa", writeAddr, 32'd1); chk("tie_w1_wd", writeData, 32'hAAAA);
      step();
      neg(); chk("tie_w2_wo", writeOrder, 32'd1); chk("tie_w2_wd", writeData, 32'h5555);
      step();
      neg(); chk("tie_end_wo", writeOrder, 32'd0);
      aluReq = 1'b1; aluAddr = 3'd6; aluData = 16'h1111;
      memReq = 1'b1; memAddr = 3'd7; memData = 16'h2222;
      step();
      aluReq = 1'b0; memReq = 1'b0;
      step();
      neg(); chk("tie2_first_wd", writeData, 32'h2222);
      step();
      neg(); chk("tie2_second_wd", writeData, 32'h1111);
      idle(2);

      // Same-address ordering: older mem write commits before younger ALU write
      memReq = 1'b1; memAddr = 3'd5; memData = 16'h0001;
      step();
      memReq = 1'b0;
      aluReq = 1'b1; aluAddr = 3'd5; aluData = 16'h0002;
      neg(); chk("order_pending_wo", writeOrder, 32'd0);
      step();
      aluReq = 1'b0;
      neg(); chk("order_w1_wa", writeAddr, 32'd5); chk("order_w1_wd", writeData, 32'h0001);
      step();
      neg(); chk("order_w2_wo", writeOrder, 32'd1); chk("order_w2_wd", writeData, 32'h0002);
      idle(2);

      // Hazard tracking through buffer and write port
      aluReq = 1'b1; aluAddr = 3'd4; aluData = 16'hBEEF;
      readAddr1 = 3'd4; readAddr2 = 3'd6;
      step();
      aluReq = 1'b0;
      neg(); chk("haz_buf_h1", hazard1, 32'd1); chk("haz_buf_h2", hazard2, 32'd0);
      step();
      neg(); chk("haz_wr_h1", hazard1, 32'd1); chk("haz_wr_wo", writeOrder, 32'd1);
      step();
      neg(); chk("haz_clear_h1", hazard1, 32'd0);
      idle(1);

      // Streaming: one ALU write per cycle
      for (int j = 0; j < 11; j++) begin
         if (j < 8) begin
            aluReq = 1'b1; aluAddr = j[2:0]; aluData = 16'h0100 + 16'(j);
         end else begin
            aluReq = 1'b0;
         end
         neg();
         if (j < 8) chk("stream_ack", aluAck, 32'd1);
         if (j >= 2 && j < 10) begin
            chk("stream_wo", writeOrder, 32'd1);
            chk("stream_wd", writeData, 32'h0100 + 32'(j - 2));
         end
         if (j == 10) chk("stream_end_wo", writeOrder, 32'd0);
         step();
      end
      idle(1);

      // Reset mid-operation with both buffers full
      doReset();
      aluReq = 1'b1; aluAddr = 3'd2; aluData = 16'hC0DE;
      memReq = 1'b1; memAddr = 3'd3; memData = 16'hD00D;
      readAddr1 = 3'd2; readAddr2 = 3'd3;
      step();
      resetN = 1'b0;
      neg();
      chk("rst_aluAck", aluAck, 32'd0); chk("rst_memAck", memAck, 32'd0);
      chk("rst_busy_before", busy, 32'd1);
      step();
      resetN = 1'b1; aluReq = 1'b0; memReq = 1'b0;
      neg();
      chk("rst_busy_after", busy, 32'd0);
      chk("rst_h1_after", hazard1, 32'd0); chk("rst_h2_after", hazard2, 32'd0);
      for (int k = 0; k < 3; k++) begin
         chk("rst_no_write", writeOrder, 32'd0);
         step();
         neg();
      end

      // Randomized traffic with occasional resets
      for (int n = 0; n < 3000; n++) begin
         step();
         resetN    = ($urandom_range(0, 99) != 0);
         aluReq    = ($urandom_range(0, 9) < 6);
         memReq    = ($urandom_range(0, 9) < 6);
         aluAddr   = 3'($urandom_range(0, 7));
         memAddr   = 3'($urandom_range(0, 7));
         aluData   = 16'($urandom);
         memData   = 16'($urandom);
         readAddr1 = 3'($urandom_range(0, 7));
         readAddr2 = 3'($urandom_range(0, 7));
      end
      resetN = 1'b1;
      idle(4);
      neg();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
